// File: rtl/spi_flash_read_cache.sv
// spi_flash_read_cache
//   Direct-mapped, one-word-per-line read cache in front of MappedSPIFlash.
//   Hits return data the cycle after the strobe; misses run one flash read
//   and fill the indexed line. Flash is never written through this block.
//   Optional feature macro: FLASH_CACHE_PREFETCH_EN (sequential next-line
//   prefetch after each demand fill).
// Ports
//   i_clk                 system clock
//   i_reset               synchronous active-low reset
//   i_mem_rstrb           CPU read strobe (1-cycle pulse)
//   i_mem_word_address    CPU word address, sampled with i_mem_rstrb
//   o_mem_rdata           read data, valid in the first cycle o_mem_rbusy is low
//   o_mem_rbusy           high while a CPU read is outstanding
//   i_cache_flush         1-cycle pulse, invalidates all lines
//   o_flash_rstrb         read strobe to MappedSPIFlash (1-cycle pulse)
//   o_flash_word_address  word address to MappedSPIFlash, held until fill done
//   i_flash_rdata         read data from MappedSPIFlash
//   i_flash_rbusy         busy from MappedSPIFlash
module spi_flash_read_cache #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned LINES_LOG2 = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rstrb,
  input  logic [ADDR_W-1:0] i_mem_word_address,
  output logic [31:0]       o_mem_rdata,
  output logic              o_mem_rbusy,
  input  logic              i_cache_flush,
  output logic              o_flash_rstrb,
  output logic [ADDR_W-1:0] o_flash_word_address,
  input  logic [31:0]       i_flash_rdata,
  input  logic              i_flash_rbusy
);

  localparam int unsigned LINES  = 1 << LINES_LOG2;
  localparam int unsigned TAG_W  = ADDR_W - LINES_LOG2;
  localparam int unsigned DATA_W = 32;

`ifdef FLASH_CACHE_PREFETCH_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_PF_ISSUE, S_PF_SETTLE, S_PF_WAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT
  } state_t;
`endif

  state_t                  r_state, w_state_nxt;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [DATA_W-1:0]       r_data [LINES];
  logic [DATA_W-1:0]       r_mem_rdata, w_mem_rdata_nxt;
  logic                    r_mem_rbusy, w_mem_rbusy_nxt;
  logic                    r_flash_rstrb, w_flash_rstrb_nxt;
  logic [ADDR_W-1:0]       r_flash_addr, w_flash_addr_nxt;
  // Set when a flush lands while a fill is in flight: that fill must not
  // mark its line valid.
  logic                    r_kill, w_kill_nxt;

  logic                    w_req;
  logic [ADDR_W-1:0]       w_lk_addr;
  logic [LINES_LOG2-1:0]   w_lk_idx;
  logic                    w_hit;
  logic                    w_line_we;
  logic [LINES_LOG2-1:0]   w_fill_idx;
  logic [TAG_W-1:0]        w_fill_tag;

`ifdef FLASH_CACHE_PREFETCH_EN
  // A CPU strobe that arrives during a prefetch is parked here and replayed
  // as a normal lookup once the prefetch line is written.
  logic                    r_held, w_held_nxt;
  logic [ADDR_W-1:0]       r_held_addr, w_held_addr_nxt;
  logic [ADDR_W-1:0]       w_pf_addr;
  logic [LINES_LOG2-1:0]   w_pf_idx;
  logic                    w_pf_hit;

  assign w_req     = (i_mem_rstrb & ~r_mem_rbusy) | r_held;
  assign w_lk_addr = r_held ? r_held_addr : i_mem_word_address;
  assign w_pf_addr = r_flash_addr + ADDR_W'(1);
  assign w_pf_idx  = w_pf_addr[LINES_LOG2-1:0];
  assign w_pf_hit  = r_valid[w_pf_idx] && (r_tag[w_pf_idx] == w_pf_addr[ADDR_W-1:LINES_LOG2]);
`else
  assign w_req     = i_mem_rstrb;
  assign w_lk_addr = i_mem_word_address;
`endif

  assign w_lk_idx   = w_lk_addr[LINES_LOG2-1:0];
  assign w_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_addr[ADDR_W-1:LINES_LOG2]);
  // The flash address register doubles as the fill address for the line.
  assign w_fill_idx = r_flash_addr[LINES_LOG2-1:0];
  assign w_fill_tag = r_flash_addr[ADDR_W-1:LINES_LOG2];

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_rdata_nxt   = r_mem_rdata;
    w_mem_rbusy_nxt   = r_mem_rbusy;
    w_flash_rstrb_nxt = 1'b0;
    w_flash_addr_nxt  = r_flash_addr;
    w_kill_nxt        = r_kill | i_cache_flush;
    w_line_we         = 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
    w_held_nxt        = r_held;
    w_held_addr_nxt   = r_held_addr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
`ifdef FLASH_CACHE_PREFETCH_EN
          w_held_nxt = 1'b0;
`endif
          if (w_hit) begin
            w_mem_rdata_nxt = r_data[w_lk_idx];
            w_mem_rbusy_nxt = 1'b0;
          end else begin
            w_mem_rbusy_nxt   = 1'b1;
            w_flash_rstrb_nxt = 1'b1;
            w_flash_addr_nxt  = w_lk_addr;
            w_kill_nxt        = i_cache_flush;
            w_state_nxt       = S_ISSUE;
          end
        end
      end
      S_ISSUE:  w_state_nxt = S_SETTLE;
      // Controller raises rbusy one cycle after it sees the strobe.
      S_SETTLE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!i_flash_rbusy) begin
          w_mem_rdata_nxt = i_flash_rdata;
          w_mem_rbusy_nxt = 1'b0;
          w_line_we       = 1'b1;
          w_state_nxt     = S_IDLE;
`ifdef FLASH_CACHE_PREFETCH_EN
          if (!w_pf_hit) begin
            w_flash_rstrb_nxt = 1'b1;
            w_flash_addr_nxt  = w_pf_addr;
            w_kill_nxt        = i_cache_flush;
            w_state_nxt       = S_PF_ISSUE;
          end
`endif
        end
      end
`ifdef FLASH_CACHE_PREFETCH_EN
      S_PF_ISSUE, S_PF_SETTLE, S_PF_WAIT: begin
        if (i_mem_rstrb && !r_mem_rbusy) begin
          w_held_nxt      = 1'b1;
          w_held_addr_nxt = i_mem_word_address;
          w_mem_rbusy_nxt = 1'b1;
        end
        if (r_state == S_PF_ISSUE) begin
          w_state_nxt = S_PF_SETTLE;
        end else if (r_state == S_PF_SETTLE) begin
          w_state_nxt = S_PF_WAIT;
        end else if (!i_flash_rbusy) begin
          w_line_we   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, output and control registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_mem_rdata   <= '0;
      r_mem_rbusy   <= 1'b0;
      r_flash_rstrb <= 1'b0;
      r_flash_addr  <= '0;
      r_kill        <= 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
      r_held        <= 1'b0;
      r_held_addr   <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
      r_mem_rbusy   <= w_mem_rbusy_nxt;
      r_flash_rstrb <= w_flash_rstrb_nxt;
      r_flash_addr  <= w_flash_addr_nxt;
      r_kill        <= w_kill_nxt;
`ifdef FLASH_CACHE_PREFETCH_EN
      r_held        <= w_held_nxt;
      r_held_addr   <= w_held_addr_nxt;
`endif
    end
  end

  // Valid bits: flush wins over a fill landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_valid <= '0;
    end else if (i_cache_flush) begin
      r_valid <= '0;
    end else if (w_line_we) begin
      r_valid[w_fill_idx] <= ~r_kill;
    end
  end

  // Tag/data storage; a fill overwrites the indexed line unconditionally.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_line_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_flash_rdata;
    end
  end

  assign o_mem_rdata          = r_mem_rdata;
  assign o_mem_rbusy          = r_mem_rbusy;
  assign o_flash_rstrb        = r_flash_rstrb;
  assign o_flash_word_address = r_flash_addr;

endmodule

// File: tb/tb_spi_flash_read_cache.sv
// Bench for spi_flash_read_cache with a simple behavioural flash controller.
module tb_spi_flash_read_cache;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned LAT    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_rstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rbusy;
  logic              cache_flush;
  logic              flash_rstrb;
  logic [ADDR_W-1:0] flash_addr;
  logic [31:0]       flash_rdata;
  logic              flash_rbusy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // flash model state
  int              n_strobes;
  logic [ADDR_W-1:0] last_addr;
  int              f_cnt;

  always #5 clk = ~clk;

  spi_flash_read_cache #(.ADDR_W(ADDR_W), .LINES_LOG2(4)) dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_mem_rstrb          (mem_rstrb),
    .i_mem_word_address   (mem_addr),
    .o_mem_rdata          (mem_rdata),
    .o_mem_rbusy          (mem_rbusy),
    .i_cache_flush        (cache_flush),
    .o_flash_rstrb        (flash_rstrb),
    .o_flash_word_address (flash_addr),
    .i_flash_rdata        (flash_rdata),
    .i_flash_rbusy        (flash_rbusy)
  );

  function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
    return {a[7:0], 4'hC, a} ^ 32'h3C96_A501;
  endfunction

  // Flash controller model: busy for LAT cycles after a strobe, garbage data
  // while busy, shares the cache reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      flash_rbusy <= 1'b0;
      f_cnt       <= 0;
      flash_rdata <= 32'h0;
    end else if (f_cnt != 0) begin
      f_cnt <= f_cnt - 1;
      if (f_cnt == 1) begin
        flash_rbusy <= 1'b0;
        flash_rdata <= pat(last_addr);
      end
    end else if (flash_rstrb) begin
      flash_rbusy <= 1'b1;
      f_cnt       <= LAT;
      flash_rdata <= 32'hDEAD_BEEF;
      last_addr   <= flash_addr;
      n_strobes   <= n_strobes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic settle();
    repeat (LAT + 15) @(negedge clk);
  endtask

  // One CPU read; flush_at: -1 none, 0 with the strobe, k>0 k cycles later.
  task automatic rd(input logic [ADDR_W-1:0] a, input bit hit, input int flush_at, input string tag);
    int s0;
    int i;
    settle();
    s0 = n_strobes;
    mem_rstrb   = 1'b1;
    mem_addr    = a;
    cache_flush = (flush_at == 0);
    exp_q.push_back(pat(a));
    @(negedge clk);
    mem_rstrb   = 1'b0;
    cache_flush = 1'b0;
    chk({tag, " busy_after_strobe"}, 32'(mem_rbusy), 32'(!hit));
    i = 1;
    while (mem_rbusy && i < 200) begin
      cache_flush = (i == flush_at);
      @(negedge clk);
      i++;
    end
    cache_flush = 1'b0;
    chk({tag, " busy_released"}, 32'(mem_rbusy), 32'h0);
    chk({tag, " data"}, mem_rdata, exp_q.pop_front());
    chk({tag, " flash_strobes"}, 32'(n_strobes - s0), hit ? 32'd0 : 32'd1);
    if (!hit) chk({tag, " flash_addr"}, 32'(last_addr), 32'(a));
  endtask

  initial begin
    int s0;
    int i;
    n_strobes   = 0;
    last_addr   = '0;
    rst_n       = 1'b0;
    mem_rstrb   = 1'b0;
    mem_addr    = '0;
    cache_flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset rbusy", 32'(mem_rbusy), 32'h0);
    chk("reset rdata", mem_rdata, 32'h0);
    chk("reset frstrb", 32'(flash_rstrb), 32'h0);
    chk("reset faddr", 32'(flash_addr), 32'h0);

    rd(20'h00003, 1'b0, -1, "cold3");
    rd(20'h00003, 1'b1, -1, "rehit3");
    rd(20'h00013, 1'b0, -1, "conflict13");
    rd(20'h00003, 1'b0, -1, "conflict3");
    rd(20'h00003, 1'b1, -1, "hit3b");

    // flush alone, then miss
    settle();
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    rd(20'h00003, 1'b0, -1, "post_flush3");
    // flush coincident with a hit: served from old contents, then misses
    rd(20'h00003, 1'b1, 0, "hit_with_flush3");
    rd(20'h00003, 1'b0, -1, "after_hit_flush3");
    // flush during a miss: data returned, line not valid
    rd(20'h00007, 1'b0, 6, "miss_with_flush7");
    rd(20'h00007, 1'b0, -1, "refetch7");
    rd(20'h00007, 1'b1, -1, "hit7");
    // all-ones address
    rd(20'hFFFFF, 1'b0, -1, "ones_miss");
    rd(20'hFFFFF, 1'b1, -1, "ones_hit");

    // reset while waiting on flash
    settle();
    s0 = n_strobes;
    mem_rstrb = 1'b1;
    mem_addr  = 20'h00005;
    @(negedge clk);
    mem_rstrb = 1'b0;
    repeat (6) @(negedge clk);
    chk("wait busy_before_reset", 32'(mem_rbusy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset rbusy", 32'(mem_rbusy), 32'h0);
    chk("midreset frstrb", 32'(flash_rstrb), 32'h0);
    chk("midreset faddr", 32'(flash_addr), 32'h0);
    chk("midreset rdata", mem_rdata, 32'h0);
    chk("midreset strobes", 32'(n_strobes - s0), 32'd1);
    rd(20'h00005, 1'b0, -1, "after_reset5");
    rd(20'h00003, 1'b0, -1, "after_reset3");

`ifdef FLASH_CACHE_PREFETCH_EN
    // prefetch wraps 0xFFFFF -> 0x00000
    settle();
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    rd(20'hFFFFF, 1'b0, -1, "pf_ones");
    s0 = n_strobes;
    i  = 0;
    while (n_strobes == s0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("pf strobe_count", 32'(n_strobes - s0), 32'd1);
    chk("pf addr", 32'(last_addr), 32'h0);
    chk("pf rbusy", 32'(mem_rbusy), 32'h0);
    rd(20'h00000, 1'b1, -1, "pf_hit0");
    // strobe during prefetch is held and replayed as a hit
    rd(20'h00020, 1'b0, -1, "pf_miss20");
    @(negedge clk);
    mem_rstrb = 1'b1;
    mem_addr  = 20'h00021;
    exp_q.push_back(pat(20'h00021));
    @(negedge clk);
    mem_rstrb = 1'b0;
    s0 = n_strobes;
    chk("pf held busy", 32'(mem_rbusy), 32'h1);
    i = 0;
    while (mem_rbusy && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("pf held released", 32'(mem_rbusy), 32'h0);
    chk("pf held data", mem_rdata, exp_q.pop_front());
    chk("pf held strobes", 32'(n_strobes - s0), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
